// File: rtl/adc_lane_packer.sv
// Capture-window ADC lane packer: NUM_LANES x LANE_W lanes -> PACK-lane words over PIPE_STAGES registers.
// Optional per-word even parity output pack_par when ADC_PACK_PARITY_EN is defined.

module adc_lane_s0 #(
  parameter int LANE_W   = 9,
  parameter int LANE_IDX = 0
) (
  input  logic [1:0]        sel_i,
  input  logic [LANE_W-1:0] adc_i,
  input  logic [LANE_W-1:0] ramp_i,
  input  logic [LANE_W-1:0] hold_i,
  output logic [LANE_W-1:0] d_o
);
  localparam logic [LANE_W-1:0] OFS = LANE_W'(LANE_IDX);

  always_comb begin
    d_o = adc_i;
    case (sel_i)
      2'd1:    d_o = ramp_i + OFS;
      2'd2:    d_o = hold_i;
      default: d_o = adc_i;
    endcase
  end
endmodule

module adc_lane_packer #(
  parameter int NUM_LANES   = 96,
  parameter int LANE_W      = 9,
  parameter int PACK        = 4,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                        ANA_ADC_CLK500M,
  input  logic                        adc96_rstn,
  input  logic [NUM_LANES*LANE_W-1:0] adc_data,
  input  logic [1:0]                  cfg_mode,
  input  logic                        cfg_trig_en,
  input  logic [CNT_W-1:0]            cap_len,
  input  logic                        cap_start,
  input  logic                        cap_stop,
  input  logic                        trig,
  output logic [NUM_LANES*LANE_W-1:0] pack_data,
  output logic                        pack_valid,
  output logic                        cap_busy,
  output logic                        cap_done
`ifdef ADC_PACK_PARITY_EN
  ,
  output logic [NUM_LANES/PACK-1:0]   pack_par
`endif
);
  localparam int NW     = NUM_LANES / PACK;
  localparam int WORD_W = PACK * LANE_W;

  if (NUM_LANES % PACK != 0 || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_cfg
    $error("adc_lane_packer: illegal parameterisation");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic       trig_en;
    logic       len_inf;
  } cap_cfg_t;

  state_t                            state_q, state_d;
  cap_cfg_t                          cfg_q, cfg_d;
  logic [CNT_W-1:0]                  len_cnt_q, len_cnt_d;
  logic [LANE_W-1:0]                 ramp_q, ramp_d;
  logic                              stopped_q, stopped_d;
  logic                              beat, done0;
  logic [1:0]                        lane_sel;

  logic [NUM_LANES-1:0][LANE_W-1:0]  adc_lanes, s0_d;
  logic [PIPE_STAGES-1:0][NUM_LANES-1:0][LANE_W-1:0] dat_pipe;
  logic [PIPE_STAGES-1:0]            vld_pipe, done_pipe;

  assign adc_lanes = adc_data;
  assign cap_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    len_cnt_d = len_cnt_q;
    ramp_d    = ramp_q;
    stopped_d = 1'b0;
    beat      = 1'b0;
    done0     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cap_start && !cap_stop) begin
          state_d       = S_ARM;
          cfg_d.mode    = cfg_mode;
          cfg_d.trig_en = cfg_trig_en;
          cfg_d.len_inf = (cap_len == '0);
          len_cnt_d     = cap_len;
          ramp_d        = '0;
        end
      end
      S_ARM: begin
        if (cap_stop)                      state_d = S_IDLE;
        else if (!cfg_q.trig_en || trig)   state_d = S_CAP;
      end
      S_CAP: begin
        // The stop cycle ends the window itself, so it is not a beat.
        if (cap_stop) begin
          state_d   = S_DONE;
          stopped_d = 1'b1;
          done0     = 1'b1;
        end else begin
          beat   = 1'b1;
          ramp_d = ramp_q + LANE_W'(1);
          if (!cfg_q.len_inf) begin
            len_cnt_d = len_cnt_q - CNT_W'(1);
            if (len_cnt_q == CNT_W'(1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done0   = !stopped_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ANA_ADC_CLK500M or negedge adc96_rstn) begin
    if (!adc96_rstn) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      len_cnt_q <= '0;
      ramp_q    <= '0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      len_cnt_q <= len_cnt_d;
      ramp_q    <= ramp_d;
      stopped_q <= stopped_d;
    end
  end

  // Mode 3 is reserved and falls through to pass.
  always_comb begin
    lane_sel = 2'd0;
    if (beat) begin
      if (cfg_q.mode == 2'd1)      lane_sel = 2'd1;
      else if (cfg_q.mode == 2'd2) lane_sel = 2'd2;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    adc_lane_s0 #(.LANE_W(LANE_W), .LANE_IDX(i)) u_lane (
      .sel_i  (lane_sel),
      .adc_i  (adc_lanes[i]),
      .ramp_i (ramp_q),
      .hold_i (dat_pipe[0][i]),
      .d_o    (s0_d[i])
    );
  end

  always_ff @(posedge ANA_ADC_CLK500M or negedge adc96_rstn) begin
    if (!adc96_rstn) begin
      dat_pipe  <= '0;
      vld_pipe  <= '0;
      done_pipe <= '0;
    end else begin
      dat_pipe[0]  <= s0_d;
      vld_pipe[0]  <= beat;
      done_pipe[0] <= done0;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        dat_pipe[k]  <= dat_pipe[k-1];
        vld_pipe[k]  <= vld_pipe[k-1];
        done_pipe[k] <= done_pipe[k-1];
      end
    end
  end

  // Lane j*PACK+k already sits at word j, slot k in the flat bus, so packing is a plain rename.
  assign pack_data  = dat_pipe[PIPE_STAGES-1];
  assign pack_valid = vld_pipe[PIPE_STAGES-1];
  assign cap_done   = done_pipe[PIPE_STAGES-1];

`ifdef ADC_PACK_PARITY_EN
  logic [NW-1:0][WORD_W-1:0] par_src;
  logic [NW-1:0]             par_d, par_q;

  if (PIPE_STAGES == 1) begin : g_par_s0
    assign par_src = s0_d;
  end else begin : g_par_sn
    assign par_src = dat_pipe[PIPE_STAGES-2];
  end

  always_comb begin
    par_d = '0;
    for (int j = 0; j < NW; j++) par_d[j] = ^par_src[j];
  end

  always_ff @(posedge ANA_ADC_CLK500M or negedge adc96_rstn) begin
    if (!adc96_rstn) par_q <= '0;
    else             par_q <= par_d;
  end

  assign pack_par = par_q;
`endif

endmodule

// File: tb/tb_adc_lane_packer.sv
// Directed bench for adc_lane_packer: vector table for FSM framing plus ramp, continuous,
// freeze (3-stage instance) and mid-capture reset sequences.

module tb_adc_lane_packer;
  localparam int NL = 96, LW = 9, PK = 4, CW = 16;
  localparam int BW = NL * LW, NW = NL / PK, WW = PK * LW;

  logic          clk = 1'b0, rstn = 1'b0;
  logic [BW-1:0] adc;
  logic [1:0]    mode;
  logic          ten, start, stop, trig;
  logic [CW-1:0] len;
  logic [BW-1:0] pd1, pd3;
  logic          pv1, pv3, pb1, pb3, pdn1, pdn3;
`ifdef ADC_PACK_PARITY_EN
  logic [NW-1:0] par1, par3;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  adc_lane_packer #(.NUM_LANES(NL), .LANE_W(LW), .PACK(PK), .PIPE_STAGES(1), .CNT_W(CW)) u_dut (
    .ANA_ADC_CLK500M(clk), .adc96_rstn(rstn), .adc_data(adc), .cfg_mode(mode),
    .cfg_trig_en(ten), .cap_len(len), .cap_start(start), .cap_stop(stop), .trig(trig),
    .pack_data(pd1), .pack_valid(pv1), .cap_busy(pb1), .cap_done(pdn1)
`ifdef ADC_PACK_PARITY_EN
    , .pack_par(par1)
`endif
  );

  adc_lane_packer #(.NUM_LANES(NL), .LANE_W(LW), .PACK(PK), .PIPE_STAGES(3), .CNT_W(CW)) u_dut3 (
    .ANA_ADC_CLK500M(clk), .adc96_rstn(rstn), .adc_data(adc), .cfg_mode(mode),
    .cfg_trig_en(ten), .cap_len(len), .cap_start(start), .cap_stop(stop), .trig(trig),
    .pack_data(pd3), .pack_valid(pv3), .cap_busy(pb3), .cap_done(pdn3)
`ifdef ADC_PACK_PARITY_EN
    , .pack_par(par3)
`endif
  );

  typedef struct {
    logic          start, stop, trig;
    logic [1:0]    mode;
    logic          ten;
    logic [CW-1:0] len;
    logic          ev, eb, ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, sp, tr, input logic [1:0] md, input logic te,
                              input int ln, input logic ev, eb, ed);
    vec_t v;
    v.start = st; v.stop = sp; v.trig = tr; v.mode = md; v.ten = te; v.len = CW'(ln);
    v.ev = ev; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endfunction

  // Lane i = (base + i*mul) mod 512, assembled word by word, slot k of word j.
  function automatic logic [BW-1:0] lane_bus(input int base, input int mul);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++)
      for (int k = 0; k < PK; k++)
        v[j*WW + k*LW +: LW] = LW'((base + (j*PK + k) * mul) % 512);
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*LW +: LW] = LW'($urandom);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = NL - 1; i >= 0; i--)
        if (act[i*LW +: LW] !== exp[i*LW +: LW]) bad = i;
      $display("FAIL %s lane %0d act=%0h exp=%0h", nm, bad, act[bad*LW +: LW], exp[bad*LW +: LW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; trig = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] pat, p0;
    logic [35:0]   w0exp;
    logic [NW-1:0] ep;
    int            nval;

    adc = rand_bus(); mode = 2'd0; ten = 1'b0; len = '0;
    idle_in();
    w0exp = {9'd3, 9'd2, 9'd1, 9'd0};

    // ---- reset state ----
    #3;
    chk_b("rst_valid", pv1, 1'b0);
    chk_b("rst_busy", pb1, 1'b0);
    chk_b("rst_done", pdn1, 1'b0);
    chk_bus("rst_data", pd1, '0);
    step(); step();
    rstn = 1'b1;
    step();
    chk_b("post_rst_valid", pv1, 1'b0);
    chk_b("post_rst_busy", pb1, 1'b0);

    // ---- vector table ----
    // A: pass, len 5
    add(1,0,0,2'd0,0,5, 0,1,0);
    add(0,0,0,2'd0,0,0, 0,1,0);
    for (int i = 0; i < 5; i++) add(0,0,0,2'd0,0,0, 1,1,0);
    add(0,0,0,2'd0,0,0, 0,0,1);
    add(0,0,0,2'd0,0,0, 0,0,0);
    // B: trigger held low for 10 cycles
    add(1,0,0,2'd0,1,3, 0,1,0);
    for (int i = 0; i < 10; i++) add(0,0,0,2'd0,0,0, 0,1,0);
    add(0,0,1,2'd0,0,0, 0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,2'd0,0,0, 1,1,0);
    add(0,0,0,2'd0,0,0, 0,0,1);
    add(0,0,0,2'd0,0,0, 0,0,0);
    // C: stop while armed
    add(1,0,0,2'd0,1,3, 0,1,0);
    add(0,1,0,2'd0,0,0, 0,0,0);
    add(0,0,0,2'd0,0,0, 0,0,0);
    add(0,0,1,2'd0,0,0, 0,0,0);
    // D: simultaneous start+stop in IDLE
    add(1,1,0,2'd0,0,4, 0,0,0);
    add(0,0,0,2'd0,0,0, 0,0,0);
    add(0,0,1,2'd0,0,0, 0,0,0);

    pat = lane_bus(0, 1);
    adc = pat;
    foreach (vecs[n]) begin
      start = vecs[n].start; stop = vecs[n].stop; trig = vecs[n].trig;
      mode = vecs[n].mode; ten = vecs[n].ten; len = vecs[n].len;
      step();
      chk_b($sformatf("tbl%0d_valid", n), pv1, vecs[n].ev);
      chk_b($sformatf("tbl%0d_busy", n), pb1, vecs[n].eb);
      chk_b($sformatf("tbl%0d_done", n), pdn1, vecs[n].ed);
      if (vecs[n].ev) begin
        chk_bus($sformatf("tbl%0d_data", n), pd1, pat);
        chk($sformatf("tbl%0d_word0", n), 64'(pd1[35:0]), 64'(w0exp));
      end
    end
    idle_in();

    // ---- ramp, 600 beats, wraps mod 512 ----
    mode = 2'd1; ten = 1'b0; len = CW'(600); start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_b("ramp_arm_valid", pv1, 1'b0);
    for (int b = 0; b < 600; b++) begin
      adc = rand_bus();
      step();
      chk_b($sformatf("ramp%0d_valid", b), pv1, 1'b1);
      chk_bus($sformatf("ramp%0d_data", b), pd1, lane_bus(b, 1));
    end
    step();
    chk_b("ramp_end_valid", pv1, 1'b0);
    chk_b("ramp_end_done", pdn1, 1'b1);
    step();
    chk_b("ramp_idle_done", pdn1, 1'b0);

    // ---- continuous capture, stop after 20 beats, start mid-window ignored ----
    mode = 2'd0; len = '0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    nval = 0;
    for (int c = 0; c < 20; c++) begin
      pat = lane_bus(c * 3 + 1, 7);
      adc = pat;
      if (c == 5) begin
        start = 1'b1; mode = 2'd1; len = CW'(2);
      end else start = 1'b0;
      step();
      if (pv1) nval++;
      chk_bus($sformatf("cont%0d_data", c), pd1, pat);
      chk_b($sformatf("cont%0d_busy", c), pb1, 1'b1);
    end
    chk("cont_beats", 64'(nval), 64'd20);
    start = 1'b0; stop = 1'b1; adc = rand_bus();
    step();
    chk_b("cont_stop_valid", pv1, 1'b0);
    chk_b("cont_stop_done", pdn1, 1'b1);
    chk_b("cont_stop_busy", pb1, 1'b1);
    stop = 1'b0;
    step();
    chk_b("cont_after_done", pdn1, 1'b0);
    chk_b("cont_after_busy", pb1, 1'b0);
    chk_b("cont_after_valid", pv1, 1'b0);

    // ---- freeze, len 6, checked on both 1- and 3-stage instances ----
    p0 = lane_bus(100, 1);
    adc = p0;
    step(); step(); step();
    mode = 2'd2; len = CW'(6); start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < NW; j++) ep[j] = ^p0[j*WW +: WW];
    for (int s = 1; s <= 11; s++) begin
      if (s >= 2) adc = rand_bus();
      step();
      chk_b($sformatf("frz%0d_v1", s), pv1, (s >= 2 && s <= 7));
      chk_b($sformatf("frz%0d_d1", s), pdn1, (s == 8));
      chk_b($sformatf("frz%0d_v3", s), pv3, (s >= 4 && s <= 9));
      chk_b($sformatf("frz%0d_d3", s), pdn3, (s == 10));
      if (pv1) chk_bus($sformatf("frz%0d_data1", s), pd1, p0);
      if (pv3) chk_bus($sformatf("frz%0d_data3", s), pd3, p0);
`ifdef ADC_PACK_PARITY_EN
      if (pv3) chk($sformatf("frz%0d_par3", s), 64'(par3), 64'(ep));
`endif
    end

    // ---- reset mid-capture ----
    mode = 2'd0; len = '0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk_b("mid_pre_valid", pv1, 1'b1);
    adc = rand_bus();
    rstn = 1'b0;
    #1;
    chk_b("mid_rst_valid", pv1, 1'b0);
    chk_b("mid_rst_busy", pb1, 1'b0);
    chk_b("mid_rst_done", pdn1, 1'b0);
    chk_bus("mid_rst_data", pd1, '0);
    chk_bus("mid_rst_data3", pd3, '0);
    chk_b("mid_rst_valid3", pv3, 1'b0);
    step();
    chk_b("mid_rst_hold_done", pdn1, 1'b0);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      adc = rand_bus();
      step();
      chk_b($sformatf("mid_rel%0d_valid", c), pv1, 1'b0);
      chk_b($sformatf("mid_rel%0d_done", c), pdn1, 1'b0);
      chk_b($sformatf("mid_rel%0d_busy", c), pb1, 1'b0);
      chk_b($sformatf("mid_rel%0d_done3", c), pdn3, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_lane_packer.md
Name: adc_lane_packer

Overview:
- Parametrised successor to the fixed 96-lane/4-per-word ADC packing register stage in the analog top.
- Packs NUM_LANES ADC lanes of LANE_W bits into NUM_LANES/PACK output words of PACK*LANE_W bits, retimed on ANA_ADC_CLK500M.
- Adds capture-window control, a ramp test-pattern mode and a freeze mode, so the downstream capture logic gets framed, validated data with a programmable pipeline depth.

Parameters:
- NUM_LANES, 96, number of ADC lanes; must be a multiple of PACK.
- LANE_W, 9, bits per lane.
- PACK, 4, lanes per output word; lane k*PACK sits in the word LSBs.
- PIPE_STAGES, 1, register stages from adc_data to pack_data; legal range 1..4.
- CNT_W, 16, width of the capture length counter.

Ports:
- ANA_ADC_CLK500M  in  1  datapath and control clock.
- adc96_rstn  in  1  reset.
- adc_data  in  NUM_LANES*LANE_W  flat lane bus; lane i occupies bits [i*LANE_W +: LANE_W].
- cfg_mode  in  2  0=pass, 1=ramp, 2=freeze, 3=reserved (behaves as pass); sampled on an accepted cap_start.
- cfg_trig_en  in  1  1=wait for trig in ARM; sampled on an accepted cap_start.
- cap_len  in  CNT_W  capture length in cycles; 0=continuous until cap_stop; sampled on an accepted cap_start.
- cap_start  in  1  single-cycle start pulse.
- cap_stop  in  1  single-cycle abort/stop pulse.
- trig  in  1  level trigger, used in ARM.
- pack_data  out  NUM_LANES*LANE_W  packed words; word j occupies bits [j*PACK*LANE_W +: PACK*LANE_W].
- pack_valid  out  1  pack_data belongs to the capture window.
- cap_busy  out  1  FSM is not IDLE.
- cap_done  out  1  one-cycle pulse at the end of a window.

Behaviour:
- Reset: adc96_rstn, asynchronous, active-low; clock ANA_ADC_CLK500M.
  - All pipeline registers, pack_data, pack_valid, cap_busy and cap_done reset to 0.
  - FSM resets to IDLE, ramp_cnt to 0, latched mode to pass.
  - Reset mid-capture aborts immediately; cap_done does not pulse.
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE -> ARM on cap_start when cap_stop=0. This latches cfg_mode, cfg_trig_en, cap_len, sets len_cnt=cap_len and clears ramp_cnt.
  - cap_start and cap_stop in the same cycle while in IDLE: stay in IDLE.
  - ARM -> CAPTURE when (cfg_trig_en=0) or (trig=1), evaluated in the ARM cycle, so the minimum ARM dwell is 1 cycle.
  - ARM -> IDLE on cap_stop (no cap_done).
  - CAPTURE: each cycle emits one stage-0 beat with valid=1.
    - If latched cap_len != 0: len_cnt decrements; on the beat where len_cnt==1, go to DONE. Exactly cap_len beats are emitted.
    - If cap_len == 0: stay in CAPTURE until cap_stop. The cap_stop cycle itself is not a valid beat.
  - cap_stop in CAPTURE -> DONE.
  - DONE -> IDLE after 1 cycle.
  - cap_start outside IDLE is ignored.
- Stage-0 data, per lane i, according to the latched mode:
  - pass: adc_data lane i.
  - ramp: (ramp_cnt + i) mod 2^LANE_W. ramp_cnt increments once per CAPTURE beat and wraps at 2^LANE_W.
  - freeze: the stage-0 register holds its current value.
  - Outside CAPTURE the datapath runs in pass mode with valid=0 (legacy free-running behaviour).
- Pipeline: stage-0 data and valid travel PIPE_STAGES register stages together.
  - pack_data and pack_valid appear PIPE_STAGES cycles after the adc_data sample edge.
  - cap_done is delayed by the same pipeline so it is aligned one cycle after the last pack_valid beat.
- cap_busy is combinational from FSM state: 1 in ARM, CAPTURE, DONE.
- Packing is pure bit ordering: word j = {lane j*PACK+PACK-1, ..., lane j*PACK}. No arithmetic is applied to lane data.

Optional Feature:
- Macro ADC_PACK_PARITY_EN.
- Defined: adds output pack_par [NUM_LANES/PACK-1:0].
  - Bit j is the even parity (XOR) of packed word j.
  - Registered in the final pipeline stage, aligned with pack_data.
  - Reset value 0.
- Undefined: port and logic are absent; latency is unchanged.

Test Plan:
- Reset: assert adc96_rstn=0 mid-capture with random adc_data -> all outputs 0, FSM IDLE, no cap_done; after release with no start, pack_valid stays 0.
- Pass, PIPE_STAGES=1, cfg_trig_en=0, cap_len=5, lane i = i mod 512 -> word 0 = {9'd3,9'd2,9'd1,9'd0}; exactly 5 pack_valid beats; cap_done 1 cycle after the last beat; cap_busy high from the cycle after start to the DONE cycle.
- Ramp, cap_len=600 -> lane 0 reads 0,1,...,511,0,...,87; lane 95 starts at 95; every lane wraps mod 512.
- Trigger: cfg_trig_en=1, trig held low 10 cycles then high -> no valid during ARM; capture starts the cycle after trig is seen; cap_stop during ARM -> IDLE with no cap_done.
- Continuous: cap_len=0, cap_stop after 20 beats -> exactly 20 valid beats, then cap_done; simultaneous cap_start+cap_stop in IDLE -> no capture; cap_start during CAPTURE -> ignored.
- Freeze with PIPE_STAGES=3 (plus ADC_PACK_PARITY_EN) -> pack_data constant at the pre-start value throughout the window, first valid 3 cycles after CAPTURE entry; pack_par[j] equals the XOR of word j.
